// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: board position encoding, movement
// directions, FSM state encoding, power-up board constants and small helpers
// for stepping a position and building the LED image.
package snake_pkg;

    // A board cell is {row[2:0], col[2:0]}; bit index in the LED image is row*8+col.
    localparam int POS_W = 6;
    typedef logic [POS_W-1:0] pos_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_CHECK,
        ST_COMMIT,
        ST_FOOD_REQ,
        ST_FOOD_WAIT,
        ST_DONE
    } state_t;

    // Starting snake: three cells along row 3, head at the right-hand end.
    localparam pos_t        INIT_TAIL = 6'd24;  // (3,0)
    localparam pos_t        INIT_MID  = 6'd25;  // (3,1)
    localparam pos_t        INIT_HEAD = 6'd26;  // (3,2)
    localparam pos_t        INIT_FOOD = 6'd29;  // (3,5)
    localparam logic [63:0] INIT_OCC  = 64'h0000_0000_0700_0000;

    // One step in the given direction; row and column wrap independently mod 8.
    function automatic pos_t pos_step(input pos_t pos, input dir_t dir);
        logic [2:0] row;
        logic [2:0] col;
        row = pos[5:3];
        col = pos[2:0];
        case (dir)
            DIR_UP:    row = row - 3'd1;
            DIR_DOWN:  row = row + 3'd1;
            DIR_LEFT:  col = col - 3'd1;
            DIR_RIGHT: col = col + 3'd1;
            default:   row = row;
        endcase
        return {row, col};
    endfunction

    function automatic logic [63:0] onehot64(input pos_t pos);
        return 64'd1 << pos;
    endfunction

    // Displayed board: body plus food, with the head dark while blinking.
    function automatic logic [63:0] led_image(input logic [63:0] occ, input pos_t food,
                                              input pos_t head, input logic blink);
        logic [63:0] img;
        img = occ | onehot64(food);
        if (blink) begin
            img[head] = 1'b0;
        end
        return img;
    endfunction

endpackage

// File: rtl/snake_body_ring.sv
// Circular buffer holding the snake body, oldest segment (tail) first.
//   clka      in   system clock
//   clear     in   synchronous load of the three-segment starting body
//   push      in   append push_pos as the new head
//   pop       in   drop the tail segment (may coincide with push)
//   push_pos  in   cell written on push
//   head_pos  out  newest segment
//   tail_pos  out  oldest segment
//   length    out  number of valid segments
module snake_body_ring
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 6
) (
    input  logic             clka,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [5:0]       push_pos,
    output logic [5:0]       head_pos,
    output logic [5:0]       tail_pos,
    output logic [LEN_W-1:0] length
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    // NOTE: storage is not reset; clear loads only the live entries, and every
    // read goes through pointers that only ever cover written slots.
    logic [5:0]       mem [MAX_LEN];
    logic [LEN_W-1:0] head_ptr;
    logic [LEN_W-1:0] tail_ptr;
    logic [LEN_W-1:0] head_nxt;
    logic [LEN_W-1:0] tail_nxt;
    logic [LEN_W-1:0] length_q;

    function automatic logic [LEN_W-1:0] ptr_inc(input logic [LEN_W-1:0] ptr);
        return (ptr == LEN_W'(MAX_LEN - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign head_nxt = ptr_inc(head_ptr);
    assign tail_nxt = ptr_inc(tail_ptr);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clka) begin
        if (clear) begin
            mem[0]   <= INIT_TAIL;
            mem[1]   <= INIT_MID;
            mem[2]   <= INIT_HEAD;
            tail_ptr <= '0;
            head_ptr <= LEN_W'(2);
            length_q <= LEN_W'(3);
        end else begin
            // When full, the new head lands in the tail slot, which is popped
            // on the same edge, so nothing live is overwritten.
            if (push) begin
                mem[head_nxt[IDX_W-1:0]] <= push_pos;
                head_ptr                 <= head_nxt;
            end
            if (pop) begin
                tail_ptr <= tail_nxt;
            end
            case ({push, pop})
                2'b10:   length_q <= length_q + 1'b1;
                2'b01:   length_q <= length_q - 1'b1;
                default: length_q <= length_q;
            endcase
        end
    end

    assign head_pos = mem[head_ptr[IDX_W-1:0]];
    assign tail_pos = mem[tail_ptr[IDX_W-1:0]];
    assign length   = length_q;

endmodule

// File: rtl/snake_logic.sv
// Snake game-board datapath. Each logic_tick either moves the snake one cell
// (checking for body collision, growing on food and fetching new food from the
// PRNG) or, when paused or after the game has ended, toggles the head blink.
//   clka             in   system clock
//   restart          in   synchronous active-high reset
//   logic_tick       in   start one step (ignored unless idle)
//   no_update        in   with logic_tick: blink only, no move
//   direction_state  in   0=UP 1=DOWN 2=LEFT 3=RIGHT, sampled with logic_tick
//   food_req         out  request a new food cell from the PRNG
//   food_ack         in   food_pos valid
//   food_pos         in   {row,col} candidate food cell
//   logic_done       out  one-cycle pulse when the step is finished
//   game_end         out  sticky collision flag
//   led_array        out  registered board image, bit row*8+col
module snake_logic
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 6
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        logic_tick,
    input  logic        no_update,
    input  logic [1:0]  direction_state,
    output logic        food_req,
    input  logic        food_ack,
    input  logic [5:0]  food_pos,
    output logic        logic_done,
    output logic        game_end,
    output logic [63:0] led_array
);

    state_t           state;
    state_t           state_nxt;
    logic [63:0]      occupancy;
    logic [63:0]      occ_commit;
    logic [63:0]      led_q;
    pos_t             food;
    pos_t             next_head;
    dir_t             dir_q;
    logic             grow;
    logic             blink;
    logic             game_end_q;
    logic             food_req_q;
    logic             hit;
    logic             can_grow;
    logic             ring_push;
    logic             ring_pop;
    logic [5:0]       head_pos;
    logic [5:0]       tail_pos;
    logic [LEN_W-1:0] ring_len;

    snake_body_ring #(
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) u_ring (
        .clka    (clka),
        .clear   (restart),
        .push    (ring_push),
        .pop     (ring_pop),
        .push_pos(next_head),
        .head_pos(head_pos),
        .tail_pos(tail_pos),
        .length  (ring_len)
    );

    // The cell the tail leaves this step is free to enter, unless the snake
    // grows, in which case the tail stays put.
    assign hit      = occupancy[next_head] & ~((next_head == tail_pos) & ~grow);
    assign can_grow = grow & (ring_len < LEN_W'(MAX_LEN));

    always_ff @(posedge clka) begin
        if (restart) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        ring_push = 1'b0;
        ring_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (logic_tick) begin
                    state_nxt = (no_update | game_end_q) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC:  state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = hit ? ST_DONE : ST_COMMIT;
            ST_COMMIT: begin
                ring_push = 1'b1;
                // A full snake that eats still moves normally: length saturates.
                ring_pop  = ~can_grow;
                state_nxt = grow ? ST_FOOD_REQ : ST_DONE;
            end
            ST_FOOD_REQ: state_nxt = ST_FOOD_WAIT;
            ST_FOOD_WAIT: begin
                if (food_ack) begin
                    state_nxt = occupancy[food_pos] ? ST_FOOD_REQ : ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Board after this step's push/pop; setting the head after clearing the
    // tail keeps the bit lit when the head enters the vacated tail cell.
    always_comb begin
        occ_commit = occupancy;
        if (ring_pop) begin
            occ_commit[tail_pos] = 1'b0;
        end
        occ_commit[next_head] = 1'b1;
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            occupancy  <= INIT_OCC;
            food       <= INIT_FOOD;
            led_q      <= INIT_OCC | onehot64(INIT_FOOD);
            next_head  <= INIT_HEAD;
            dir_q      <= DIR_RIGHT;
            grow       <= 1'b0;
            blink      <= 1'b0;
            game_end_q <= 1'b0;
            food_req_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (logic_tick) begin
                        dir_q <= dir_t'(direction_state);
                        if (no_update | game_end_q) begin
                            blink <= ~blink;
                            led_q <= led_image(occupancy, food, head_pos, ~blink);
                        end
                    end
                end
                ST_CALC: begin
                    next_head <= pos_step(head_pos, dir_q);
                    grow      <= (pos_step(head_pos, dir_q) == food);
                end
                ST_CHECK: begin
                    if (hit) begin
                        game_end_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    occupancy <= occ_commit;
                    led_q     <= led_image(occ_commit, food, next_head, blink);
                end
                ST_FOOD_REQ: begin
                    food_req_q <= 1'b1;
                end
                ST_FOOD_WAIT: begin
                    // Dropping the request on every ack guarantees at least one
                    // low cycle before a re-request for an occupied cell.
                    if (food_ack) begin
                        food_req_q <= 1'b0;
                        if (!occupancy[food_pos]) begin
                            food  <= food_pos;
                            led_q <= led_image(occupancy, food_pos, head_pos, blink);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign food_req   = food_req_q;
    assign logic_done = (state == ST_DONE);
    assign game_end   = game_end_q;
    assign led_array  = led_q;

endmodule
